// File: rtl/eth_dma_packer_pkg.sv
// Shared types and trailer field layout for eth_dma_packer.
// Optional timestamp feature: ETH_DMA_PACKER_TIMESTAMP_EN (see eth_dma_packer.sv).
package eth_dma_packer_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DATA    = 3'd1,
    S_FLUSH   = 3'd2,
    S_TRAILER = 3'd3,
    S_DISCARD = 3'd4
  } state_t;

  localparam int DMA_BYTES = 16;
  localparam int DMA_W     = DMA_BYTES * 8;

  localparam int CNT_LSB   = 0;
  localparam int CH_LSB    = 16;
  localparam int ERR_BIT   = 24;
  localparam int TRUNC_BIT = 25;
  localparam int TS_LSB    = 64;

  function automatic logic [DMA_W-1:0] make_trailer(
    input logic [15:0] cnt,
    input logic [2:0]  ch,
    input logic        err,
    input logic        trunc,
    input logic [63:0] ts
  );
    logic [DMA_W-1:0] t;
    t = '0;
    t[CNT_LSB +: 16] = cnt;
    t[CH_LSB +: 3]   = ch;
    t[ERR_BIT]       = err;
    t[TRUNC_BIT]     = trunc;
    t[TS_LSB +: 64]  = ts;
    return t;
  endfunction

endpackage

// File: rtl/eth_dma_packer_rr_arbiter.sv
// Round-robin frame arbiter: scans from last grant + 1 and remembers the winner
// when the caller strobes load.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          load,
  output logic [IW-1:0] grant,
  output logic          grant_valid
);

  logic [IW-1:0] last;
  logic [IW-1:0] cand;
  int            idx;

  always_comb begin
    grant       = last;
    grant_valid = 1'b0;
    idx         = 0;
    cand        = '0;
    for (int i = 1; i <= N; i++) begin
      idx = int'(last) + i;
      if (idx >= N) idx = idx - N;
      cand = IW'(idx);
      if (!grant_valid && req[cand]) begin
        grant       = cand;
        grant_valid = 1'b1;
      end
    end
  end

  // Reset to the top channel so channel 0 wins the first scan.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last <= IW'(N - 1);
    end else if (load && grant_valid) begin
      last <= grant;
    end
  end

endmodule

// File: rtl/eth_dma_packer.sv
// Multi-channel 8-bit to 128-bit frame packer with a per-frame trailer beat.
// Define ETH_DMA_PACKER_TIMESTAMP_EN to carry a capture timestamp in trailer [127:64].
module eth_dma_packer
  import eth_dma_packer_pkg::*;
#(
  parameter int NUM_CHANNELS    = 4,
  parameter int MAX_FRAME_BYTES = 2048
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [8*NUM_CHANNELS-1:0] s_axis_eth_tdata,
  input  logic [NUM_CHANNELS-1:0]   s_axis_eth_tuser,
  input  logic [NUM_CHANNELS-1:0]   s_axis_eth_tlast,
  input  logic [NUM_CHANNELS-1:0]   s_axis_eth_tvalid,
  output logic [NUM_CHANNELS-1:0]   s_axis_eth_tready,
  output logic [DMA_W-1:0]          m_axis_dma_tdata,
  output logic                      m_axis_dma_tlast,
  output logic                      m_axis_dma_tvalid,
  input  logic                      m_axis_dma_tready,
  output logic [2:0]                dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and held data is stable while stalled.

  localparam int IW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  state_t          state, state_nxt;
  logic [IW-1:0]   ch;
  logic [IW-1:0]   arb_grant;
  logic            arb_valid;
  logic [3:0]      byte_idx;
  logic [15:0]     byte_cnt;
  logic            err, trunc, last_seen;
  logic [DMA_W-1:0] acc;
  logic [DMA_W-1:0] out_data;
  logic [63:0]     ts_val;

  logic            out_free, byte_ready, accept, cnt_hit;
  logic            load_grant, load_beat, load_flush, load_trailer;
  logic            sel_valid, sel_last, sel_user;
  logic [7:0]      sel_data;

  rr_arbiter #(.N(NUM_CHANNELS)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (s_axis_eth_tvalid),
    .load        (load_grant),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_user  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (ch == IW'(i)) begin
        sel_valid = s_axis_eth_tvalid[i];
        sel_last  = s_axis_eth_tlast[i];
        sel_user  = s_axis_eth_tuser[i];
        sel_data  = s_axis_eth_tdata[8*i +: 8];
      end
    end
  end

  assign out_free = !m_axis_dma_tvalid || m_axis_dma_tready;
  assign cnt_hit  = (byte_cnt == 16'(MAX_FRAME_BYTES - 1));
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    load_grant   = 1'b0;
    byte_ready   = 1'b0;
    accept       = 1'b0;
    load_beat    = 1'b0;
    load_flush   = 1'b0;
    load_trailer = 1'b0;
    case (state)
      S_IDLE: begin
        if (arb_valid) begin
          load_grant = 1'b1;
          state_nxt  = S_DATA;
        end
      end
      S_DATA: begin
        // Only the beat-completing byte depends on the output register.
        byte_ready = (byte_idx != 4'd15) || out_free;
        accept     = byte_ready && sel_valid;
        load_beat  = accept && (byte_idx == 4'd15);
        if (accept && (sel_last || cnt_hit)) begin
          state_nxt = (byte_idx == 4'd15) ? S_TRAILER : S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (out_free) begin
          load_flush = 1'b1;
          state_nxt  = S_TRAILER;
        end
      end
      S_TRAILER: begin
        if (out_free) begin
          load_trailer = 1'b1;
          state_nxt    = (trunc && !last_seen) ? S_DISCARD : S_IDLE;
        end
      end
      S_DISCARD: begin
        byte_ready = 1'b1;
        accept     = sel_valid;
        if (sel_valid && sel_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    s_axis_eth_tready = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      s_axis_eth_tready[i] = byte_ready && (ch == IW'(i));
    end
  end

  // The accumulator is cleared at grant and after every full beat, so a
  // flushed partial beat already has its unused upper bytes at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch        <= '0;
      byte_idx  <= '0;
      byte_cnt  <= '0;
      err       <= 1'b0;
      trunc     <= 1'b0;
      last_seen <= 1'b0;
      acc       <= '0;
    end else begin
      if (load_grant) begin
        ch        <= arb_grant;
        byte_idx  <= '0;
        byte_cnt  <= '0;
        err       <= 1'b0;
        trunc     <= 1'b0;
        last_seen <= 1'b0;
        acc       <= '0;
      end
      if (state == S_DATA && accept) begin
        byte_cnt <= byte_cnt + 16'd1;
        err      <= err | sel_user;
        if (byte_idx == 4'd15) begin
          acc      <= '0;
          byte_idx <= '0;
        end else begin
          acc[8*byte_idx +: 8] <= sel_data;
          byte_idx             <= byte_idx + 4'd1;
        end
        if (sel_last)     last_seen <= 1'b1;
        else if (cnt_hit) trunc     <= 1'b1;
      end
    end
  end

  always_comb begin
    if (load_trailer)    out_data = make_trailer(byte_cnt, 3'(ch), err, trunc, ts_val);
    else if (load_flush) out_data = acc;
    else                 out_data = {sel_data, acc[DMA_W-9:0]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_axis_dma_tvalid <= 1'b0;
      m_axis_dma_tdata  <= '0;
      m_axis_dma_tlast  <= 1'b0;
    end else if (load_beat || load_flush || load_trailer) begin
      m_axis_dma_tvalid <= 1'b1;
      m_axis_dma_tdata  <= out_data;
      m_axis_dma_tlast  <= load_trailer;
    end else if (m_axis_dma_tready) begin
      m_axis_dma_tvalid <= 1'b0;
    end
  end

`ifdef ETH_DMA_PACKER_TIMESTAMP_EN
  logic [63:0] ts_cnt, ts_cap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_cnt <= '0;
      ts_cap <= '0;
    end else begin
      ts_cnt <= ts_cnt + 64'd1;
      if (state == S_DATA && accept && byte_cnt == 16'd0) ts_cap <= ts_cnt;
    end
  end

  assign ts_val = ts_cap;
`else
  assign ts_val = '0;
`endif

endmodule

// File: tb/tb_eth_dma_packer.sv
// Directed bench for eth_dma_packer: default instance plus a MAX_FRAME_BYTES=32
// instance for truncation, checked against a frame model's expected beat queue.
module tb_eth_dma_packer;
  import eth_dma_packer_pkg::*;

  localparam int NC = 4;

`ifdef ETH_DMA_PACKER_TIMESTAMP_EN
  localparam logic [128:0] CMP_MASK = {1'b1, 64'h0, {64{1'b1}}};
`else
  localparam logic [128:0] CMP_MASK = {129{1'b1}};
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [8*NC-1:0] tdata;
  logic [NC-1:0]   tuser, tlast, tvalid;
  logic            m_tready;
  logic            bp_mode;
  logic            use_tr;

  logic [NC-1:0]   d_tready, t_tready, s_tready;
  logic [127:0]    d_mdata, t_mdata, s_mdata;
  logic            d_mlast, t_mlast, s_mlast;
  logic            d_mvalid, t_mvalid, s_mvalid;
  logic [2:0]      d_state, t_state, s_state;

  eth_dma_packer #(.NUM_CHANNELS(NC), .MAX_FRAME_BYTES(2048)) dut (
    .clk (clk), .rst_n (rst_n),
    .s_axis_eth_tdata (tdata), .s_axis_eth_tuser (tuser),
    .s_axis_eth_tlast (tlast), .s_axis_eth_tvalid (tvalid),
    .s_axis_eth_tready (d_tready),
    .m_axis_dma_tdata (d_mdata), .m_axis_dma_tlast (d_mlast),
    .m_axis_dma_tvalid (d_mvalid), .m_axis_dma_tready (m_tready),
    .dbg_state (d_state)
  );

  eth_dma_packer #(.NUM_CHANNELS(NC), .MAX_FRAME_BYTES(32)) dut_tr (
    .clk (clk), .rst_n (rst_n),
    .s_axis_eth_tdata (tdata), .s_axis_eth_tuser (tuser),
    .s_axis_eth_tlast (tlast), .s_axis_eth_tvalid (tvalid),
    .s_axis_eth_tready (t_tready),
    .m_axis_dma_tdata (t_mdata), .m_axis_dma_tlast (t_mlast),
    .m_axis_dma_tvalid (t_mvalid), .m_axis_dma_tready (m_tready),
    .dbg_state (t_state)
  );

  assign s_tready = use_tr ? t_tready : d_tready;
  assign s_mdata  = use_tr ? t_mdata  : d_mdata;
  assign s_mlast  = use_tr ? t_mlast  : d_mlast;
  assign s_mvalid = use_tr ? t_mvalid : d_mvalid;
  assign s_state  = use_tr ? t_state  : d_state;

  // scoreboard
  logic [128:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [128:0] got, input logic [128:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic void push_frame(input int ch, input int n, input int base,
                                     input int errpos, input int maxb);
    logic [127:0] beat;
    logic [127:0] trl;
    int kept;
    kept = (n > maxb) ? maxb : n;
    beat = '0;
    for (int i = 0; i < kept; i++) begin
      beat[8*(i%16) +: 8] = 8'(base + i);
      if (i % 16 == 15) begin
        exp_q.push_back({1'b0, beat});
        beat = '0;
      end
    end
    if (kept % 16 != 0) exp_q.push_back({1'b0, beat});
    trl = '0;
    trl[15:0]  = 16'(kept);
    trl[18:16] = 3'(ch);
    trl[24]    = (errpos >= 0) && (errpos < kept);
    trl[25]    = (n > maxb);
    exp_q.push_back({1'b1, trl});
  endfunction

  // driver tasks
  task automatic drive_bytes(input int ch, input int n, input int base,
                             input int errpos, input bit last);
    int waited;
    for (int i = 0; i < n; i++) begin
      tdata[8*ch +: 8] = 8'(base + i);
      tuser[ch]  = (i == errpos);
      tlast[ch]  = last && (i == n - 1);
      tvalid[ch] = 1'b1;
      waited = 0;
      @(negedge clk);
      while (!s_tready[ch] && waited < 200) begin
        waited++;
        @(negedge clk);
      end
      if (!s_tready[ch]) begin
        check("drv_timeout", 129'(s_tready[ch]), 129'(1));
        tvalid[ch] = 1'b0;
        tlast[ch]  = 1'b0;
        tuser[ch]  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    tvalid[ch] = 1'b0;
    tlast[ch]  = 1'b0;
    tuser[ch]  = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("drain", 129'(exp_q.size()), 129'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = bp_mode ? ~m_tready : 1'b1;
    end
  end

  // output monitor
  logic         prev_stall;
  logic [128:0] prev_beat;
  logic [128:0] got_beat;
  logic [128:0] want_beat;

  always @(negedge clk) begin
    if (rst_n) begin
      got_beat = {s_mlast, s_mdata};
      if (prev_stall) begin
        check("hold_valid", 129'(s_mvalid), 129'(1));
        check("hold_data", got_beat, prev_beat);
      end
      if (s_mvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 129'(exp_q.size()), 129'(1));
        end else begin
          want_beat = exp_q.pop_front();
          check("beat", got_beat & CMP_MASK, want_beat & CMP_MASK);
        end
      end
      if ($countones(s_tready) > 1) check("tready_onehot", 129'($countones(s_tready)), 129'(1));
      prev_stall <= s_mvalid && !m_tready;
      prev_beat  <= got_beat;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    tdata   = '0;
    tuser   = '0;
    tlast   = '0;
    tvalid  = '0;
    bp_mode = 1'b0;
    use_tr  = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mvalid", 129'(s_mvalid), 129'(0));
    check("rst_mdata", 129'(s_mdata), 129'(0));
    check("rst_mlast", 129'(s_mlast), 129'(0));
    check("rst_tready", 129'(s_tready), 129'(0));
    check("rst_state", 129'(s_state), 129'(S_IDLE));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single full beat on channel 0
    push_frame(0, 16, 8'h00, -1, 2048);
    drive_bytes(0, 16, 8'h00, -1, 1'b1);
    wait_drain();

    // round-robin: ch1 and ch3 request together, ch1 keeps requesting
    push_frame(1, 5, 8'h10, -1, 2048);
    push_frame(3, 20, 8'h30, -1, 2048);
    push_frame(1, 3, 8'h50, -1, 2048);
    fork
      begin
        drive_bytes(1, 5, 8'h10, -1, 1'b1);
        drive_bytes(1, 3, 8'h50, -1, 1'b1);
      end
      drive_bytes(3, 20, 8'h30, -1, 1'b1);
    join
    wait_drain();

    // padded frame on channel 2
    push_frame(2, 17, 8'h00, -1, 2048);
    drive_bytes(2, 17, 8'h00, -1, 1'b1);
    wait_drain();

    // toggling backpressure over a 48-byte frame
    bp_mode = 1'b1;
    push_frame(0, 48, 8'h80, -1, 2048);
    drive_bytes(0, 48, 8'h80, -1, 1'b1);
    wait_drain();
    bp_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset after 7 bytes of a frame on channel 1
    drive_bytes(1, 7, 8'hA0, -1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_mvalid", 129'(s_mvalid), 129'(0));
    check("midrst_mdata", 129'(s_mdata), 129'(0));
    check("midrst_mlast", 129'(s_mlast), 129'(0));
    check("midrst_tready", 129'(s_tready), 129'(0));
    check("midrst_state", 129'(s_state), 129'(S_IDLE));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // after reset channel 0 beats channel 2 even though ch1 was last granted
    push_frame(0, 4, 8'hC0, -1, 2048);
    push_frame(2, 4, 8'hD0, -1, 2048);
    fork
      drive_bytes(0, 4, 8'hC0, -1, 1'b1);
      drive_bytes(2, 4, 8'hD0, -1, 1'b1);
    join
    wait_drain();

    // truncation on the 32-byte instance, error on byte 5, then a normal frame
    use_tr = 1'b1;
    push_frame(0, 40, 8'h00, 5, 32);
    drive_bytes(0, 40, 8'h00, 5, 1'b1);
    push_frame(1, 5, 8'hE0, -1, 32);
    drive_bytes(1, 5, 8'hE0, -1, 1'b1);
    wait_drain();
    check("final_state", 129'(s_state), 129'(S_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_dma_packer.md
# eth_dma_packer

Multi-channel frame packer between the per-port 8-bit Ethernet capture streams and the 128-bit DMA stream toward PCIe. It arbitrates whole frames round-robin across NUM_CHANNELS inputs, packs bytes little-endian into 128-bit beats, and terminates every frame with a trailer beat. The trailer carries the channel, the byte count and the error flags, and optionally a capture timestamp. All inputs are already in the `clk` domain.

## Interface
- NUM_CHANNELS, 4: input stream count, 1..8.
- MAX_FRAME_BYTES, 2048: truncation limit, 16..65535.
- clk  in  1  single clock; everything is on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- s_axis_eth_tdata  in  8*NUM_CHANNELS  channel i in bits [8i+7:8i].
- s_axis_eth_tuser  in  NUM_CHANNELS  per-byte error flag.
- s_axis_eth_tlast  in  NUM_CHANNELS  last byte of frame.
- s_axis_eth_tvalid  in  NUM_CHANNELS  byte valid.
- s_axis_eth_tready  out  NUM_CHANNELS  byte accepted; at most one bit high.
- m_axis_dma_tdata  out  128  packed beat or trailer.
- m_axis_dma_tlast  out  1  set only on trailer beats.
- m_axis_dma_tvalid  out  1  beat valid.
- m_axis_dma_tready  in  1  DMA accepts beat.

## Operation
- **State machine:** IDLE, DATA, FLUSH, TRAILER, DISCARD.
- **IDLE:**
  - Scan channels starting at last_grant+1 (mod NUM_CHANNELS) and grant the first channel with tvalid high.
  - Update last_grant and clear byte_cnt, err and trunc.
  - Go to DATA next cycle. No byte is accepted in the grant cycle.
- **Accepting bytes in DATA:**
  - A byte is accepted when the granted tvalid and tready are both high.
  - tready is high when byte_idx != 15, or when the output register is free (!m_tvalid || m_tready).
  - The accepted byte is written to accumulator bits [8*byte_idx+7 : 8*byte_idx].
  - byte_cnt increments by 1. err |= tuser.
- **Full beat:** on the 16th byte the accumulator moves to the output register (tlast=0) and byte_idx wraps to 0.
- **End of frame in DATA:**
  - tlast with byte_idx = 15: go to TRAILER.
  - tlast with byte_idx < 15: go to FLUSH.
- **Truncation:**
  - If byte_cnt reaches MAX_FRAME_BYTES without tlast, set trunc.
  - Then go to FLUSH if a partial beat is pending, else TRAILER.
  - The trailer is followed by DISCARD.
- **FLUSH:** when the output register is free, load the accumulator with unused upper bytes zeroed, then go to TRAILER.
- **TRAILER:** when the output register is free, load the trailer (tlast=1).
  - Next state is DISCARD if trunc was set and tlast has not yet been seen, else IDLE.
- **DISCARD:**
  - Hold the granted tready high and drop all bytes.
  - On the accepted byte with tlast, go to IDLE. Nothing is emitted.
- **Trailer layout:**
  - [15:0] byte_cnt: bytes written, padding excluded.
  - [18:16] channel index.
  - [24] err.
  - [25] trunc.
  - [63:26] zero.
  - [127:64] timestamp, or zero.
- **Arithmetic:**
  - byte_cnt is 16 bits and never wraps, because of the MAX_FRAME_BYTES bound.
  - The channel index is zero-extended to 3 bits.

## Timing
- **Reset values:**
  - All outputs are 0: m_axis_dma_tvalid, tdata and tlast, and every s_axis_eth_tready bit.
  - State IDLE, last_grant = NUM_CHANNELS-1, so channel 0 wins first.
  - Reset asserted mid-frame aborts the frame. No trailer is produced and any pending output beat is dropped.
- **Output register:** one register stage.
  - tdata and tlast are stable while tvalid=1 and tready=0.
  - Load and drain may occur in the same cycle.
- **Latency:** the first byte is accepted 1 cycle after the grant. A full beat appears on m_axis_dma the cycle after its 16th byte is accepted.
- **Throughput:** 1 byte/cycle sustained with m_axis_dma_tready=1. FLUSH and TRAILER each cost one cycle.
- **Frame gap:** IDLE costs one cycle between frames.
- **Non-granted channels:** their tready is always 0, and their tvalid is ignored until the next IDLE.
- **Backpressure:** in DATA with byte_idx=15 and a blocked output, tready drops combinationally from the output register state.

## Configuration
- ETH_DMA_PACKER_TIMESTAMP_EN:
  - Defined: a 64-bit free-running cycle counter (reset 0) is captured on the first accepted byte of each frame and placed in trailer [127:64].
  - Undefined: no counter is built and trailer [127:64] is zero.

## Structure
- **Shared package eth_dma_packer_pkg:**
  - State enum.
  - Trailer field offsets: CNT_LSB=0, CH_LSB=16, ERR_BIT=24, TRUNC_BIT=25, TS_LSB=64.
  - DMA_BYTES=16.
- **Sub-module rr_arbiter** (parameter N): request vector in, grant index and a valid flag out, advancing on a load strobe.

## Test plan
- **Single full-beat frame:** channel 0 sends bytes 0x00..0x0F, tlast on 0x0F.
  - Beat 1: 0x0F0E..0100, tlast=0.
  - Trailer: [15:0]=16, ch=0, err=0, trunc=0, tlast=1.
- **Padded frame:** channel 2 sends 17 bytes 0x00..0x10.
  - Second beat is 0x...0010 with bytes 1..15 zero.
  - Trailer count 17, ch=2.
- **Round-robin:**
  - Channels 1 and 3 hold tvalid continuously; after channel 1's frame, channel 3 is granted next, then channel 1.
  - Channel 0 idle is never granted.
- **Backpressure:**
  - m_axis_dma_tready toggles 1/0 every cycle during a 48-byte frame.
  - Output tdata stays stable while stalled.
  - 3 beats + trailer, with no byte lost or duplicated.
- **Truncation:** MAX_FRAME_BYTES=32, 40-byte frame with tuser=1 on byte 5.
  - 2 beats, then trailer count 32, err=1, trunc=1.
  - The last 8 bytes are consumed with no output.
  - The next frame proceeds normally.
- **Reset mid-frame:** rst_n low for 1 cycle after 7 bytes of a frame.
  - All outputs are 0 the next cycle.
  - No trailer is emitted.
  - After reset, channel 0 is granted first.
